// File: rtl/compositor_pkg.sv
// Shared types and constants for the layer compositor: fade FSM states,
// packed RGB pixel, default 32-entry palette and the per-channel fade scaler.
package compositor_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FADING_OUT = 2'd1,
        BLACK      = 2'd2,
        FADING_IN  = 2'd3
    } fade_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int DEFAULT_PAL_DEPTH = 32;
    localparam logic [4:0] FADE_FULL = 5'd16;

    localparam logic [23:0] DEFAULT_PAL [DEFAULT_PAL_DEPTH] = '{
        24'h23405B, 24'h3A6B8C, 24'h5DA8C6, 24'hA7E0F0,
        24'h1B1B2F, 24'h3C2A4D, 24'h6B3E75, 24'h2FBDA1,
        24'h8FDE5D, 24'hD4F2A0, 24'hF2E6A0, 24'hC9A46B,
        24'h8E6B3A, 24'h5A3F26, 24'h2E2118, 24'h101010,
        24'h404040, 24'h808080, 24'hC0C0C0, 24'hFFFFFF,
        24'h7A1F2B, 24'hB83A3A, 24'hE86A4A, 24'hF5A05A,
        24'hFFD36E, 24'h3F8F4A, 24'h1E5F3A, 24'h0F3B4F,
        24'h2B6CB0, 24'h5B9BE6, 24'hC46BD9, 24'hFBAF3A
    };

    // Scales one channel by (16-lvl)/16; the 13-bit product cannot overflow.
    function automatic logic [7:0] fade_chan(input logic [7:0] c, input logic [4:0] lvl);
        logic [12:0] prod;
        prod = 13'(c) * 13'(FADE_FULL - lvl);
        return 8'(prod >> 4);
    endfunction

endpackage

// File: rtl/layer_compositor_fade_ctrl.sv
// Fade controller: four-state FSM plus 0..16 fade level, stepped once every
// FADE_DIV frame_start pulses while fading.
module fade_ctrl
    import compositor_pkg::*;
#(
    parameter int FADE_DIV = 2
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  logic       fade_out,
    input  logic       fade_in,
    output logic [4:0] level,
    output logic [1:0] state_dbg,
    output logic       busy
);

    fade_state_t state, state_nxt;
    logic [4:0]  lvl, lvl_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        step;

    assign step = frame_start && (cnt == 4'(FADE_DIV - 1));

    always_comb begin
        state_nxt = state;
        lvl_nxt   = lvl;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (fade_out) state_nxt = FADING_OUT;
            end
            FADING_OUT: begin
                // fade_out is a no-op here, but it still suppresses fade_in
                if (fade_in && !fade_out) state_nxt = FADING_IN;
                else if (lvl == FADE_FULL) state_nxt = BLACK;
                else if (frame_start) begin
                    cnt_nxt = step ? 4'd0 : cnt + 4'd1;
                    if (step) begin
                        lvl_nxt = lvl + 5'd1;
                        if (lvl == FADE_FULL - 5'd1) state_nxt = BLACK;
                    end
                end
            end
            BLACK: begin
                if (fade_in && !fade_out) state_nxt = FADING_IN;
            end
            FADING_IN: begin
                if (fade_out) state_nxt = FADING_OUT;
                else if (lvl == 5'd0) state_nxt = IDLE;
                else if (frame_start) begin
                    cnt_nxt = step ? 4'd0 : cnt + 4'd1;
                    if (step) begin
                        lvl_nxt = lvl - 5'd1;
                        if (lvl == 5'd1) state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt != state) cnt_nxt = 4'd0;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= IDLE;
            lvl   <= 5'd0;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            lvl   <= lvl_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign level     = lvl;
    assign state_dbg = state;
    assign busy      = (state == FADING_OUT) || (state == FADING_IN);

endmodule

// File: rtl/layer_compositor.sv
// Priority layer compositor: picks the top opaque layer pixel, looks it up in a
// writable palette, applies blanking and fade, and registers the RGB result.
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int ADDR_W     = 18,
    parameter int IDX_W      = 5,
    parameter int ROM_LAT    = 1,
    parameter int TRANSP_IDX = 18,
    parameter int FADE_DIV   = 2
) (
    input  logic                         clk,
    input  logic                         Reset,
    input  logic [NUM_LAYERS-1:0]        layer_draw,
    input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
    input  logic [IDX_W-1:0]             bg_idx,
    input  logic                         blank,
    input  logic                         frame_start,
    output logic [NUM_LAYERS*ADDR_W-1:0] rom_addr,
    input  logic [NUM_LAYERS*IDX_W-1:0]  rom_q,
    input  logic                         pal_we,
    input  logic [IDX_W-1:0]             pal_waddr,
    input  logic [23:0]                  pal_wdata,
    input  logic                         fade_out,
    input  logic                         fade_in,
    output logic                         fade_busy,
    output logic [1:0]                   fade_state,
    output logic [4:0]                   fade_level,
    output logic [7:0]                   Red,
    output logic [7:0]                   Green,
    output logic [7:0]                   Blue
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [NUM_LAYERS-1:0] draw_pipe  [ROM_LAT];
    logic                  blank_pipe [ROM_LAT];
    logic [IDX_W-1:0]      bg_pipe    [ROM_LAT];
    rgb_t                  pal        [DEPTH];
    logic [IDX_W-1:0]      sel_idx;
    rgb_t                  pix;
    rgb_t                  rgb_q;
    logic [4:0]            lvl;

    assign rom_addr = layer_addr;

    // Side-band controls travel alongside the ROM read so they meet rom_q.
    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                draw_pipe[i]  <= '0;
                blank_pipe[i] <= 1'b0;
                bg_pipe[i]    <= '0;
            end
        end else begin
            draw_pipe[0]  <= layer_draw;
            blank_pipe[0] <= blank;
            bg_pipe[0]    <= bg_idx;
            for (int i = 1; i < ROM_LAT; i++) begin
                draw_pipe[i]  <= draw_pipe[i-1];
                blank_pipe[i] <= blank_pipe[i-1];
                bg_pipe[i]    <= bg_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) pal[i] <= DEFAULT_PAL[i % DEFAULT_PAL_DEPTH];
        end else if (pal_we) begin
            pal[pal_waddr] <= pal_wdata;
        end
    end

    // Walk from lowest priority upward so the lowest-index opaque layer wins.
    always_comb begin
        sel_idx = bg_pipe[ROM_LAT-1];
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (draw_pipe[ROM_LAT-1][i] && (rom_q[i*IDX_W +: IDX_W] != IDX_W'(TRANSP_IDX)))
                sel_idx = rom_q[i*IDX_W +: IDX_W];
        end
    end

    assign pix = pal[sel_idx];

    always_ff @(posedge clk) begin
        if (Reset) begin
            rgb_q <= '0;
        end else if (!blank_pipe[ROM_LAT-1]) begin
            rgb_q <= '0;
        end else begin
            rgb_q.r <= fade_chan(pix.r, lvl);
            rgb_q.g <= fade_chan(pix.g, lvl);
            rgb_q.b <= fade_chan(pix.b, lvl);
        end
    end

    fade_ctrl #(
        .FADE_DIV(FADE_DIV)
    ) u_fade (
        .clk        (clk),
        .Reset      (Reset),
        .frame_start(frame_start),
        .fade_out   (fade_out),
        .fade_in    (fade_in),
        .level      (lvl),
        .state_dbg  (fade_state),
        .busy       (fade_busy)
    );

    assign fade_level = lvl;
    assign Red        = rgb_q.r;
    assign Green      = rgb_q.g;
    assign Blue       = rgb_q.b;

endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: directed table, multi-cycle fade/palette/reset
// sequences, and random traffic checked against a behavioural model.
module tb_layer_compositor;

    localparam int NL = 4;
    localparam int AW = 18;
    localparam int IW = 5;
    localparam int RL = 1;
    localparam int TR = 18;
    localparam int FD = 2;

    logic              clk = 1'b0;
    logic              Reset;
    logic [NL-1:0]     layer_draw;
    logic [NL*AW-1:0]  layer_addr;
    logic [IW-1:0]     bg_idx;
    logic              blank;
    logic              frame_start;
    logic [NL*AW-1:0]  rom_addr;
    logic [NL*IW-1:0]  rom_q;
    logic              pal_we;
    logic [IW-1:0]     pal_waddr;
    logic [23:0]       pal_wdata;
    logic              fade_out;
    logic              fade_in;
    logic              fade_busy;
    logic [1:0]        fade_state;
    logic [4:0]        fade_level;
    logic [7:0]        Red, Green, Blue;

    always #5 clk = ~clk;

    layer_compositor #(
        .NUM_LAYERS(NL), .ADDR_W(AW), .IDX_W(IW),
        .ROM_LAT(RL), .TRANSP_IDX(TR), .FADE_DIV(FD)
    ) dut (
        .clk(clk), .Reset(Reset), .layer_draw(layer_draw), .layer_addr(layer_addr),
        .bg_idx(bg_idx), .blank(blank), .frame_start(frame_start),
        .rom_addr(rom_addr), .rom_q(rom_q), .pal_we(pal_we), .pal_waddr(pal_waddr),
        .pal_wdata(pal_wdata), .fade_out(fade_out), .fade_in(fade_in),
        .fade_busy(fade_busy), .fade_state(fade_state), .fade_level(fade_level),
        .Red(Red), .Green(Green), .Blue(Blue)
    );

    // Sprite ROM: the data word is simply the low IW bits of the address.
    logic [NL*IW-1:0] rom_pipe [RL];
    always @(posedge clk) begin
        for (int l = 0; l < NL; l++) rom_pipe[0][l*IW +: IW] <= rom_addr[l*AW +: IW];
        for (int i = 1; i < RL; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_q = rom_pipe[RL-1];

    logic [23:0] ref_pal_default [32] = '{
        24'h23405B, 24'h3A6B8C, 24'h5DA8C6, 24'hA7E0F0,
        24'h1B1B2F, 24'h3C2A4D, 24'h6B3E75, 24'h2FBDA1,
        24'h8FDE5D, 24'hD4F2A0, 24'hF2E6A0, 24'hC9A46B,
        24'h8E6B3A, 24'h5A3F26, 24'h2E2118, 24'h101010,
        24'h404040, 24'h808080, 24'hC0C0C0, 24'hFFFFFF,
        24'h7A1F2B, 24'hB83A3A, 24'hE86A4A, 24'hF5A05A,
        24'hFFD36E, 24'h3F8F4A, 24'h1E5F3A, 24'h0F3B4F,
        24'h2B6CB0, 24'h5B9BE6, 24'hC46BD9, 24'hFBAF3A
    };

    typedef struct packed {
        logic [NL-1:0]    draw;
        logic [NL*IW-1:0] idxs;
        logic [IW-1:0]    bg;
        logic             blank;
    } hist_t;

    typedef struct {
        logic [3:0]  draw;
        logic [4:0]  i0, i1, i2, i3;
        logic [4:0]  bg;
        logic        blank;
        logic [23:0] exp;
    } vec_t;

    // Model state: input history, palette contents, fade level and direction.
    hist_t       hist[$];
    logic [23:0] m_pal [32];
    int          m_lvl = 0;
    int          m_dir = 0;
    int          m_frames = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    vec_t        tbl [10];

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %06h expected %06h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] model_pixel();
        hist_t       e;
        int          idx;
        logic [23:0] c;
        int          r, g, b;
        if (hist.size() <= RL) return 24'h0;
        e = hist[hist.size() - 1 - RL];
        if (!e.blank) return 24'h0;
        idx = int'(e.bg);
        for (int l = 0; l < NL; l++) begin
            if (e.draw[l] && int'(e.idxs[l*IW +: IW]) != TR) begin
                idx = int'(e.idxs[l*IW +: IW]);
                break;
            end
        end
        c = m_pal[idx];
        r = int'(c[23:16]) * (16 - m_lvl) / 16;
        g = int'(c[15:8]) * (16 - m_lvl) / 16;
        b = int'(c[7:0]) * (16 - m_lvl) / 16;
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    task automatic m_update(input logic r, input logic fo, input logic fi, input logic fs,
                            input logic we, input logic [IW-1:0] wa, input logic [23:0] wd);
        if (r) begin
            m_lvl = 0; m_dir = 0; m_frames = 0;
            hist.delete();
            for (int i = 0; i < 32; i++) m_pal[i] = ref_pal_default[i];
        end else begin
            if (we) m_pal[wa] = wd;
            if (fo && !(m_dir == 1 || (m_dir == 0 && m_lvl == 16))) begin
                m_dir = 1; m_frames = 0;
            end else if (fi && !fo && !(m_dir == -1 || (m_dir == 0 && m_lvl == 0))) begin
                m_dir = -1; m_frames = 0;
            end else if (m_dir != 0) begin
                if ((m_dir == 1 && m_lvl == 16) || (m_dir == -1 && m_lvl == 0)) begin
                    m_dir = 0; m_frames = 0;
                end else if (fs) begin
                    m_frames++;
                    if (m_frames == FD) begin
                        m_frames = 0;
                        m_lvl += m_dir;
                        if (m_lvl == 0 || m_lvl == 16) m_dir = 0;
                    end
                end
            end
        end
    endtask

    // One clock: predict, advance, then compare everything against the model.
    task automatic cyc();
        hist_t       h;
        logic [23:0] exp;
        logic        r, fo, fi, fs, we;
        logic [IW-1:0] wa;
        logic [23:0] wd;
        h.draw = layer_draw;
        for (int l = 0; l < NL; l++) h.idxs[l*IW +: IW] = layer_addr[l*AW +: IW];
        h.bg = bg_idx;
        h.blank = blank;
        hist.push_back(h);
        if (hist.size() > 8) void'(hist.pop_front());
        exp = Reset ? 24'h0 : model_pixel();
        r = Reset; fo = fade_out; fi = fade_in; fs = frame_start;
        we = pal_we; wa = pal_waddr; wd = pal_wdata;
        @(posedge clk);
        m_update(r, fo, fi, fs, we, wa, wd);
        #1;
        chk("model_rgb", {Red, Green, Blue}, exp);
        chk("model_busy", 24'(fade_busy), 24'(m_dir != 0));
        chk("model_level", 24'(fade_level), 24'(m_lvl));
    endtask

    task automatic set_layers(input logic [4:0] i0, input logic [4:0] i1,
                              input logic [4:0] i2, input logic [4:0] i3);
        logic [4:0] ix [4];
        ix[0] = i0; ix[1] = i1; ix[2] = i2; ix[3] = i3;
        for (int l = 0; l < NL; l++)
            layer_addr[l*AW +: AW] = {13'($urandom), ix[l]};
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1; cyc();
            frame_start = 1'b0; cyc(); cyc();
        end
    endtask

    task automatic pulse_out();
        fade_out = 1'b1; cyc(); fade_out = 1'b0;
    endtask

    task automatic pulse_in();
        fade_in = 1'b1; cyc(); fade_in = 1'b0;
    endtask

    initial begin
        tbl[0] = '{4'b0011, 5'd18, 5'd7,  5'd0,  5'd0,  5'd0,  1'b1, 24'h2FBDA1};
        tbl[1] = '{4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  1'b1, 24'h23405B};
        tbl[2] = '{4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 24'h000000};
        tbl[3] = '{4'b1000, 5'd0,  5'd0,  5'd0,  5'd31, 5'd0,  1'b1, 24'hFBAF3A};
        tbl[4] = '{4'b1111, 5'd18, 5'd18, 5'd3,  5'd1,  5'd0,  1'b1, 24'hA7E0F0};
        tbl[5] = '{4'b0100, 5'd0,  5'd0,  5'd18, 5'd0,  5'd19, 1'b1, 24'hFFFFFF};
        tbl[6] = '{4'b0110, 5'd5,  5'd9,  5'd2,  5'd0,  5'd0,  1'b1, 24'hD4F2A0};
        tbl[7] = '{4'b0001, 5'd0,  5'd4,  5'd0,  5'd0,  5'd2,  1'b1, 24'h23405B};
        tbl[8] = '{4'b1111, 5'd18, 5'd18, 5'd18, 5'd18, 5'd10, 1'b1, 24'hF2E6A0};
        tbl[9] = '{4'b0011, 5'd18, 5'd7,  5'd0,  5'd0,  5'd0,  1'b0, 24'h000000};

        Reset = 1'b1; layer_draw = '0; layer_addr = '0; bg_idx = '0; blank = 1'b0;
        frame_start = 1'b0; pal_we = 1'b0; pal_waddr = '0; pal_wdata = '0;
        fade_out = 1'b0; fade_in = 1'b0;
        cyc(); cyc(); cyc();
        Reset = 1'b0;
        chk("reset_rgb", {Red, Green, Blue}, 24'h000000);
        chk("reset_busy", 24'(fade_busy), 24'h0);
        chk("reset_level", 24'(fade_level), 24'h0);

        for (int v = 0; v < 10; v++) begin
            layer_draw = tbl[v].draw;
            set_layers(tbl[v].i0, tbl[v].i1, tbl[v].i2, tbl[v].i3);
            bg_idx = tbl[v].bg;
            blank = tbl[v].blank;
            for (int k = 0; k < RL + 1; k++) cyc();
            chk($sformatf("table_%0d", v), {Red, Green, Blue}, tbl[v].exp);
        end

        // Palette write to the entry being displayed: old value, then new.
        layer_draw = 4'b0010; set_layers(5'd0, 5'd7, 5'd0, 5'd0); bg_idx = '0; blank = 1'b1;
        cyc(); cyc();
        pal_we = 1'b1; pal_waddr = 5'd7; pal_wdata = 24'h123456;
        cyc();
        pal_we = 1'b0;
        chk("pal_same_cycle", {Red, Green, Blue}, 24'h2FBDA1);
        cyc();
        chk("pal_next_cycle", {Red, Green, Blue}, 24'h123456);

        // Fade out on a white pixel to black, then back in.
        layer_draw = 4'b0001; set_layers(5'd19, 5'd0, 5'd0, 5'd0);
        cyc(); cyc();
        pulse_out();
        frames(2);
        chk("fade_l1_level", 24'(fade_level), 24'd1);
        chk("fade_l1_rgb", {Red, Green, Blue}, 24'hEFEFEF);
        chk("fade_l1_busy", 24'(fade_busy), 24'h1);
        frames(30);
        chk("black_level", 24'(fade_level), 24'd16);
        chk("black_busy", 24'(fade_busy), 24'h0);
        chk("black_rgb", {Red, Green, Blue}, 24'h000000);
        pulse_out();
        frames(2);
        chk("black_ignores_out", 24'(fade_level), 24'd16);
        pulse_in();
        frames(32);
        chk("idle_level", 24'(fade_level), 24'd0);
        chk("idle_busy", 24'(fade_busy), 24'h0);
        chk("idle_rgb", {Red, Green, Blue}, 24'hFFFFFF);

        // Reverse mid-fade at L=8.
        pulse_out();
        frames(16);
        chk("mid_level", 24'(fade_level), 24'd8);
        chk("mid_rgb", {Red, Green, Blue}, 24'h7F7F7F);
        pulse_in();
        chk("rev_no_jump", 24'(fade_level), 24'd8);
        chk("rev_busy", 24'(fade_busy), 24'h1);
        frames(16);
        chk("rev_level", 24'(fade_level), 24'd0);
        chk("rev_busy_low", 24'(fade_busy), 24'h0);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            layer_draw = 4'($urandom);
            for (int l = 0; l < NL; l++)
                layer_addr[l*AW +: AW] = {13'($urandom),
                    ($urandom_range(0, 3) == 0) ? 5'd18 : 5'($urandom_range(0, 31))};
            bg_idx = 5'($urandom);
            blank = ($urandom_range(0, 7) != 0);
            pal_we = ($urandom_range(0, 9) == 0);
            pal_waddr = 5'($urandom);
            pal_wdata = 24'($urandom);
            frame_start = ($urandom_range(0, 3) == 0);
            fade_out = ($urandom_range(0, 149) == 0);
            fade_in = ($urandom_range(0, 149) == 0);
            cyc();
        end
        pal_we = 1'b0; frame_start = 1'b0; fade_out = 1'b0; fade_in = 1'b0;

        // Reset mid-fade with a palette write and fade commands pending.
        Reset = 1'b1; cyc(); Reset = 1'b0;
        layer_draw = 4'b0001; set_layers(5'd19, 5'd0, 5'd0, 5'd0); blank = 1'b1;
        pulse_out();
        frames(6);
        chk("pre_rst_level", 24'(fade_level), 24'd3);
        Reset = 1'b1; pal_we = 1'b1; pal_waddr = 5'd19; pal_wdata = 24'h000000;
        fade_in = 1'b1; fade_out = 1'b1;
        cyc();
        Reset = 1'b0; pal_we = 1'b0; fade_in = 1'b0; fade_out = 1'b0;
        chk("rst_rgb", {Red, Green, Blue}, 24'h000000);
        chk("rst_level", 24'(fade_level), 24'd0);
        chk("rst_busy", 24'(fade_busy), 24'h0);
        cyc(); cyc();
        chk("rst_pal19", {Red, Green, Blue}, 24'hFFFFFF);
        layer_draw = 4'b0010; set_layers(5'd0, 5'd7, 5'd0, 5'd0);
        cyc(); cyc();
        chk("rst_pal7", {Red, Green, Blue}, 24'h2FBDA1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
